regfile8x5_scan: RTL and testbench
==================================

# regfile8x5_scan

8-entry × 5-bit register bank with a read-scan sequencer. It sits directly upstream of the 8-to-1 5-bit select mux. It drives the mux's eight data inputs from its registers and the mux's three select lines from a handshaked scan FSM, so a consumer downstream of the mux receives a sequence of register values, one per accepted beat.

## Interface
Parameters:
- WIDTH, 5, register data width; must equal the mux data width.
- DEPTH, 8, number of registers; fixed at 8 (3-bit select).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  3  write address.
- wdata  in  5  write data.
- r0 … r7  out  5 each  register contents, wired to mux i0…i7.
- start  in  1  one-cycle scan request.
- base  in  3  first register index of the scan; sampled with start.
- len  in  4  number of beats, 0…8; sampled with start.
- s0, s1, s2  out  1 each  current select to the mux, {s2,s1,s0} = index.
- sel_valid  out  1  select lines carry a beat.
- sel_ready  in  1  downstream accepts the beat.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Reset values: all registers 0; {s2,s1,s0} = 0; sel_valid, busy, done = 0; FSM in IDLE.
- Write: if we = 1, the register at waddr takes wdata at the clock edge. The new value appears on r[waddr] in the next cycle. There is no bypass. Writes are legal in every FSM state.
- FSM states:
  - IDLE → SCAN: on start with len ≠ 0. Load idx = base and remaining = len.
  - IDLE → DONE: on start with len = 0. No beats are issued.
  - SCAN: sel_valid = 1 and {s2,s1,s0} = idx.
    - Beat accepted (sel_valid & sel_ready): idx ← idx + 1 mod 8, remaining ← remaining − 1.
    - Last beat accepted (remaining = 1): go to DONE.
    - While sel_ready = 0, idx and sel_valid hold.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in SCAN and DONE.
- start is ignored unless the FSM is in IDLE.
- Wrap-around: index 7 is followed by 0. len = 8 with any base visits every register exactly once.
- Data consistency: the downstream mux output reflects register contents at the time of acceptance. A write to idx's register in the same cycle as the accept is not seen by that beat.
- Reset mid-scan: returns to IDLE immediately. done does not pulse. Register contents are cleared.

## Timing
- start at cycle T: first beat valid in cycle T+1.
- Throughput: one beat per cycle while sel_ready = 1. A scan of len beats with sel_ready held high ends with done in cycle T+len+1.
- All outputs are registered. No combinational path from sel_ready to sel_valid or to the select lines.
- Write-to-read latency is 1 cycle.

## Configuration
- REGFILE_ZERO_R0_EN defined: register 0 is hardwired to 0. Writes to address 0 are discarded and r0 is constant 0.
- REGFILE_ZERO_R0_EN undefined: register 0 is an ordinary writable register.

## Structure
- Shared package datapath_pkg holds:
  - WIDTH = 5 and SEL_W = 3 constants.
  - The FSM state typedef (IDLE, SCAN, DONE).
- One sub-module, reg8x5_core, contains:
  - The storage array.
  - The write decode.
  - The REGFILE_ZERO_R0_EN handling.
- The top module holds the scan FSM and handshake logic.

## Test plan
- Reset, then write 5'h11 to address 3 and read r3 the next cycle → r3 = 5'h11; all other r outputs = 0.
- start with base = 6, len = 4, and sel_ready held at 1 → selects 6, 7, 0, 1 on consecutive cycles; done pulses in the cycle after select 1.
- Same scan with sel_ready low for 2 cycles on the second beat → select 7 and sel_valid held for 3 cycles; no beat skipped; done is delayed by 2 cycles.
- start with len = 0 → done pulses the next cycle and sel_valid never rises. A second start during busy is ignored.
- Assert rst_n low mid-scan at beat 2 of 5 → sel_valid, busy and done are 0 immediately; no done pulse follows; registers read 0.
- With REGFILE_ZERO_R0_EN defined, write 5'h1F to address 0 → r0 stays 0. With the macro undefined, r0 = 5'h1F.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants and scan FSM state type for the register bank
// and the select sequencer that feeds the 8-to-1 mux.
package datapath_pkg;

  localparam int WIDTH = 5;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reg8x5_core.sv
// Register storage with write decode; r0 is hardwired to zero when
// REGFILE_ZERO_R0_EN is defined, otherwise it is a normal register.
module reg8x5_core
  import datapath_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int D = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [SEL_W-1:0]        waddr,
  input  logic [W-1:0]            wdata,
  output logic [D-1:0][W-1:0]     q
);

  logic [D-1:0][W-1:0] mem;
  logic                wr_ok;

`ifdef REGFILE_ZERO_R0_EN
  assign wr_ok = (waddr != '0);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we && wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign q = mem;

endmodule

// File: rtl/regfile8x5_scan.sv
// 8x5 register bank plus handshaked scan sequencer driving mux selects.
// Optional feature: REGFILE_ZERO_R0_EN (r0 hardwired to zero).
module regfile8x5_scan
  import datapath_pkg::*;
#(
  parameter int WIDTH = datapath_pkg::WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  input  logic             start,
  input  logic [2:0]       base,
  input  logic [3:0]       len,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             busy,
  output logic             done
);

  logic [DEPTH-1:0][WIDTH-1:0] q;

  reg8x5_core #(
    .W (WIDTH),
    .D (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .q     (q)
  );

  assign r0 = q[0];
  assign r1 = q[1];
  assign r2 = q[2];
  assign r3 = q[3];
  assign r4 = q[4];
  assign r5 = q[5];
  assign r6 = q[6];
  assign r7 = q[7];

  state_t           state_q;
  logic [SEL_W-1:0] idx_q;
  logic [3:0]       rem_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // every output comes straight from a flop; sel_ready only steers next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q <= SCAN;
              idx_q   <= base;
              rem_q   <= len;
              valid_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        state_q == SCAN: begin
          if (sel_ready) begin
            idx_q <= idx_q + 3'd1;
            rem_q <= rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        state_q == DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {s2, s1, s0} = idx_q;
  assign sel_valid    = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_regfile8x5_scan.sv
// Scoreboard bench for regfile8x5_scan: directed cases then random traffic.
module tb_regfile8x5_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [4:0] wdata = '0;
  logic       start = 1'b0;
  logic [2:0] base = '0;
  logic [3:0] len = '0;
  logic       sel_ready = 1'b0;
  logic [4:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic       s0, s1, s2;
  logic       sel_valid, busy, done;

  regfile8x5_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .r5        (r5),
    .r6        (r6),
    .r7        (r7),
    .start     (start),
    .base      (base),
    .len       (len),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // reference model: register contents, beats still owed, done pending
  logic [4:0] mem [8];
  int         pend = 0;
  bit         mdone = 1'b0;
  int         expq [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [4:0] rr [8];
  assign rr[0] = r0;
  assign rr[1] = r1;
  assign rr[2] = r2;
  assign rr[3] = r3;
  assign rr[4] = r4;
  assign rr[5] = r5;
  assign rr[6] = r6;
  assign rr[7] = r7;

  function automatic void chk(string name, logic [39:0] act, logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    pend = 0;
    mdone = 1'b0;
    expq.delete();
  endfunction

  initial model_clear();

  // monitor: every falling edge compare against the model, pop on accepted beats
  always @(negedge clk) begin
    logic [2:0] sel;
    int         e;
    sel = {s2, s1, s0};
    chk("regs", {r7, r6, r5, r4, r3, r2, r1, r0},
        {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]});
    chk("sel_valid", 40'(sel_valid), 40'(pend > 0));
    chk("busy", 40'(busy), 40'((pend > 0) || mdone));
    chk("done", 40'(done), 40'(mdone));
    if (sel_valid && sel_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_extra: got select %0d expected no beat at %0t", sel, $time);
      end else begin
        e = expq.pop_front();
        chk("beat_sel", 40'(sel), 40'(e));
        chk("beat_data", 40'(rr[sel]), 40'(mem[e]));
      end
    end
  end

  // one clock of stimulus; the model advances on the same edge as the DUT
  task automatic step(input bit w, input int wa, input int wd,
                      input bit st, input int b, input int l, input bit rdy);
    we        = w;
    waddr     = 3'(wa);
    wdata     = 5'(wd);
    start     = st;
    base      = 3'(b);
    len       = 4'(l);
    sel_ready = rdy;
    @(posedge clk);
    if (rst_n) begin
      if (mdone) begin
        mdone = 1'b0;
      end else if (pend > 0) begin
        if (rdy) begin
          pend--;
          if (pend == 0) mdone = 1'b1;
        end
      end else if (st) begin
        if (l == 0) mdone = 1'b1;
        else begin
          pend = l;
          for (int i = 0; i < l; i++) expq.push_back((b + i) % 8);
        end
      end
      if (w) begin
`ifdef REGFILE_ZERO_R0_EN
        if (wa != 0) mem[wa] = 5'(wd);
`else
        mem[wa] = 5'(wd);
`endif
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    step(1, 3, 5'h11, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 5'h1F, 0, 0, 0, 0);
    idle(1);
    for (int i = 1; i < 8; i++) step(1, i, 3 * i + 1, 0, 0, 0, 0);

    step(0, 0, 0, 1, 6, 4, 1);
    idle(6);

    step(0, 0, 0, 1, 6, 4, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(6);

    step(0, 0, 0, 1, 2, 0, 1);
    idle(2);
    step(0, 0, 0, 1, 0, 3, 1);
    step(0, 0, 0, 1, 4, 2, 1);
    idle(5);

    step(0, 0, 0, 1, 5, 8, 1);
    step(1, 5, 5'h0A, 0, 0, 0, 1);
    idle(9);

    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7), $urandom_range(0, 8),
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40 && (pend > 0 || mdone); i++) idle(1);

    step(1, 4, 5'h07, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 5, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 40'(sel_valid), 40'(0));
    chk("rst_busy", 40'(busy), 40'(0));
    chk("rst_done", 40'(done), 40'(0));
    chk("rst_regs", {r7, r6, r5, r4, r3, r2, r1, r0}, 40'(0));
    model_clear();
    step(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 40 && (pend > 0 || mdone); i++) idle(1);
    chk("drained_q", 40'(expq.size()), 40'(0));
    chk("drained_fsm", 40'((pend > 0) || mdone), 40'(0));
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
